// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation-station issue scheduler.
// Also holds the CDB tag-match helper used by wakeup and the dispatch bypass.
package rs_pkg;

    localparam int unsigned RS_N     = 16;
    localparam int unsigned TAG_W    = 6;
    localparam int unsigned RS_IDX_W = $clog2(RS_N);

    typedef enum logic {ISS_IDLE, ISS_HOLD} iss_state_e;

    typedef struct packed {
        logic             valid;
        logic             held;
        logic [TAG_W-1:0] src1_tag;
        logic [TAG_W-1:0] src2_tag;
        logic             src1_rdy;
        logic             src2_rdy;
        logic [TAG_W-1:0] dest_tag;
    } rs_entry_t;

    function automatic logic tag_hit(input logic [TAG_W-1:0]   tag,
                                     input logic [1:0]         en,
                                     input logic [2*TAG_W-1:0] tags);
        return (en[0] && (tags[TAG_W-1:0] == tag)) ||
               (en[1] && (tags[2*TAG_W-1:TAG_W] == tag));
    endfunction

endpackage

// File: rtl/rs_pick2.sv
// Combinational picker: lowest and highest set bit of a mask, plus a flag
// telling whether those two are different entries.
module rs_pick2
    import rs_pkg::*;
#(
    parameter int unsigned N     = RS_N,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] lo_idx,
    output logic             lo_valid,
    output logic [IDX_W-1:0] hi_idx,
    output logic             hi_valid,
    output logic             distinct
);

    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        lo_valid = |mask;
        hi_valid = |mask;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) lo_idx = IDX_W'(i);
        end
        for (int i = 0; i < N; i++) begin
            if (mask[i]) hi_idx = IDX_W'(i);
        end
        distinct = lo_valid && (lo_idx != hi_idx);
    end

endmodule

// File: rtl/rs_issue_sched.sv
// Issue scheduler for a 16-entry reservation station: dispatch allocation,
// two-lane CDB wakeup, and two issue ports picking lowest/highest eligible.
module rs_issue_sched
    import rs_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  disp_en,
    input  logic [TAG_W-1:0]      disp_src1_tag,
    input  logic [TAG_W-1:0]      disp_src2_tag,
    input  logic                  disp_src1_rdy,
    input  logic                  disp_src2_rdy,
    input  logic [TAG_W-1:0]      disp_dest_tag,
    output logic [RS_IDX_W-1:0]   disp_idx,
    output logic                  rs_full,
    input  logic [1:0]            cdb_en,
    input  logic [2*TAG_W-1:0]    cdb_tag,
    input  logic                  flush,
    output logic [1:0]            iss_valid,
    output logic [2*RS_IDX_W-1:0] iss_idx,
    output logic [2*TAG_W-1:0]    iss_dest_tag,
    input  logic [1:0]            fu_ready
);

    rs_entry_t           entry_q [RS_N];
    rs_entry_t           entry_d [RS_N];
    iss_state_e          state_q [2];
    logic [RS_IDX_W-1:0] iss_idx_q [2];
    logic [TAG_W-1:0]    iss_dest_q [2];

    logic [RS_N-1:0]     eligible;
    logic [RS_N-1:0]     free_mask;
    logic [RS_IDX_W-1:0] lo_idx;
    logic [RS_IDX_W-1:0] hi_idx;
    logic [RS_IDX_W-1:0] free_idx;
    logic                lo_valid;
    logic                hi_valid;
    logic                distinct;
    logic                free_valid;
    logic [RS_IDX_W-1:0] unused_free_hi_idx;
    logic                unused_free_hi_valid;
    logic                unused_free_distinct;

    logic [1:0]          port_open;
    logic [1:0]          iss_done;
    logic [1:0]          load;
    logic [RS_IDX_W-1:0] pick_idx [2];

    always_comb begin
        for (int i = 0; i < RS_N; i++) begin
            eligible[i]  = entry_q[i].valid & entry_q[i].src1_rdy & entry_q[i].src2_rdy &
                           ~entry_q[i].held;
            free_mask[i] = ~entry_q[i].valid;
        end
    end

    rs_pick2 #(
        .N     (RS_N),
        .IDX_W (RS_IDX_W)
    ) u_pick_elig (
        .mask     (eligible),
        .lo_idx   (lo_idx),
        .lo_valid (lo_valid),
        .hi_idx   (hi_idx),
        .hi_valid (hi_valid),
        .distinct (distinct)
    );

    rs_pick2 #(
        .N     (RS_N),
        .IDX_W (RS_IDX_W)
    ) u_pick_free (
        .mask     (free_mask),
        .lo_idx   (free_idx),
        .lo_valid (free_valid),
        .hi_idx   (unused_free_hi_idx),
        .hi_valid (unused_free_hi_valid),
        .distinct (unused_free_distinct)
    );

    assign disp_idx = free_idx;
    assign rs_full  = ~free_valid;

    // Port 1 only yields a lone candidate to port 0 when port 0 is also loading.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            iss_done[k]  = (state_q[k] == ISS_HOLD) && fu_ready[k];
            port_open[k] = (state_q[k] == ISS_IDLE) || fu_ready[k];
        end
        load[0]     = port_open[0] && lo_valid;
        load[1]     = port_open[1] && hi_valid && (distinct || !port_open[0]);
        pick_idx[0] = lo_idx;
        pick_idx[1] = hi_idx;
    end

    always_comb begin
        entry_d = entry_q;
        for (int i = 0; i < RS_N; i++) begin
            if (entry_q[i].valid) begin
                entry_d[i].src1_rdy = entry_q[i].src1_rdy |
                                      tag_hit(entry_q[i].src1_tag, cdb_en, cdb_tag);
                entry_d[i].src2_rdy = entry_q[i].src2_rdy |
                                      tag_hit(entry_q[i].src2_tag, cdb_en, cdb_tag);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (iss_done[k]) begin
                entry_d[iss_idx_q[k]].valid = 1'b0;
                entry_d[iss_idx_q[k]].held  = 1'b0;
            end
            if (load[k]) entry_d[pick_idx[k]].held = 1'b1;
        end
        // disp_idx comes from current state, so a just-freed slot is not reused here.
        if (disp_en && !rs_full) begin
            entry_d[disp_idx].valid    = 1'b1;
            entry_d[disp_idx].held     = 1'b0;
            entry_d[disp_idx].src1_tag = disp_src1_tag;
            entry_d[disp_idx].src2_tag = disp_src2_tag;
            entry_d[disp_idx].src1_rdy = disp_src1_rdy |
                                         tag_hit(disp_src1_tag, cdb_en, cdb_tag);
            entry_d[disp_idx].src2_rdy = disp_src2_rdy |
                                         tag_hit(disp_src2_tag, cdb_en, cdb_tag);
            entry_d[disp_idx].dest_tag = disp_dest_tag;
        end
        if (flush) begin
            for (int i = 0; i < RS_N; i++) begin
                entry_d[i].valid = 1'b0;
                entry_d[i].held  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < RS_N; i++) entry_q[i] <= '0;
            for (int k = 0; k < 2; k++) begin
                state_q[k]    <= ISS_IDLE;
                iss_idx_q[k]  <= '0;
                iss_dest_q[k] <= '0;
            end
        end else begin
            entry_q <= entry_d;
            for (int k = 0; k < 2; k++) begin
                if (flush) begin
                    state_q[k] <= ISS_IDLE;
                end else if (load[k]) begin
                    state_q[k]    <= ISS_HOLD;
                    iss_idx_q[k]  <= pick_idx[k];
                    iss_dest_q[k] <= entry_q[pick_idx[k]].dest_tag;
                end else if (iss_done[k]) begin
                    state_q[k] <= ISS_IDLE;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            iss_valid[k]                         = (state_q[k] == ISS_HOLD);
            iss_idx[k*RS_IDX_W +: RS_IDX_W]      = iss_idx_q[k];
            iss_dest_tag[k*TAG_W +: TAG_W]       = iss_dest_q[k];
        end
    end

endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched: reset, back-to-back issue, fill/wakeup,
// hold stability, dispatch bypass, dual-lane wakeup and flush.
module tb_rs_issue_sched;
    import rs_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic                  disp_en;
    logic [TAG_W-1:0]      disp_src1_tag;
    logic [TAG_W-1:0]      disp_src2_tag;
    logic                  disp_src1_rdy;
    logic                  disp_src2_rdy;
    logic [TAG_W-1:0]      disp_dest_tag;
    logic [RS_IDX_W-1:0]   disp_idx;
    logic                  rs_full;
    logic [1:0]            cdb_en;
    logic [2*TAG_W-1:0]    cdb_tag;
    logic                  flush;
    logic [1:0]            iss_valid;
    logic [2*RS_IDX_W-1:0] iss_idx;
    logic [2*TAG_W-1:0]    iss_dest_tag;
    logic [1:0]            fu_ready;

    logic [RS_IDX_W-1:0]   idx0;
    logic [RS_IDX_W-1:0]   idx1;
    logic [TAG_W-1:0]      dest0;
    logic [TAG_W-1:0]      dest1;

    int checks   = 0;
    int failures = 0;

    assign idx0  = iss_idx[RS_IDX_W-1:0];
    assign idx1  = iss_idx[2*RS_IDX_W-1:RS_IDX_W];
    assign dest0 = iss_dest_tag[TAG_W-1:0];
    assign dest1 = iss_dest_tag[2*TAG_W-1:TAG_W];

    rs_issue_sched dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .disp_en       (disp_en),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_tag (disp_src2_tag),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_dest_tag (disp_dest_tag),
        .disp_idx      (disp_idx),
        .rs_full       (rs_full),
        .cdb_en        (cdb_en),
        .cdb_tag       (cdb_tag),
        .flush         (flush),
        .iss_valid     (iss_valid),
        .iss_idx       (iss_idx),
        .iss_dest_tag  (iss_dest_tag),
        .fu_ready      (fu_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset_n && disp_en && rs_full) begin
            failures++;
            $display("FAIL disp_while_full: disp_en=1 with rs_full=1 at %0t", $time);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_disp(input logic en, input logic [TAG_W-1:0] t1, input logic r1,
                            input logic [TAG_W-1:0] t2, input logic r2,
                            input logic [TAG_W-1:0] d);
        disp_en       = en;
        disp_src1_tag = t1;
        disp_src1_rdy = r1;
        disp_src2_tag = t2;
        disp_src2_rdy = r2;
        disp_dest_tag = d;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        set_disp(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        cdb_en   = 2'b00;
        cdb_tag  = '0;
        flush    = 1'b0;
        fu_ready = 2'b00;
        tick();
        tick();
        checks++;
        if (iss_valid !== 2'b00 || iss_idx !== '0 || iss_dest_tag !== '0) begin
            failures++;
            $display("FAIL reset_iss: got v=%b idx=%h dest=%h want 00/0/0",
                     iss_valid, iss_idx, iss_dest_tag);
        end
        checks++;
        if (rs_full !== 1'b0 || disp_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_disp: got full=%b idx=%0d want 0/0", rs_full, disp_idx);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (iss_valid !== 2'b00 || rs_full !== 1'b0 || disp_idx !== 4'd0) begin
                failures++;
                $display("FAIL idle_%0d: got v=%b full=%b idx=%0d want 00/0/0",
                         c, iss_valid, rs_full, disp_idx);
            end
        end
    endtask

    task automatic test_back_to_back;
        fu_ready = 2'b11;
        set_disp(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd10);
        tick();
        checks++;
        if (iss_valid !== 2'b00 || disp_idx !== 4'd1) begin
            failures++;
            $display("FAIL b2b_e1: got v=%b didx=%0d want 00/1", iss_valid, disp_idx);
        end
        disp_dest_tag = 6'd11;
        tick();
        checks++;
        if (iss_valid !== 2'b01 || idx0 !== 4'd0 || dest0 !== 6'd10) begin
            failures++;
            $display("FAIL b2b_e2: got v=%b idx0=%0d d0=%0d want 01/0/10", iss_valid, idx0, dest0);
        end
        disp_dest_tag = 6'd12;
        tick();
        checks++;
        if (iss_valid !== 2'b01 || idx0 !== 4'd1 || dest0 !== 6'd11) begin
            failures++;
            $display("FAIL b2b_e3: got v=%b idx0=%0d d0=%0d want 01/1/11", iss_valid, idx0, dest0);
        end
        // Port 0 stalls one cycle so entry 2 is left for port 1.
        disp_en  = 1'b0;
        fu_ready = 2'b10;
        tick();
        checks++;
        if (iss_valid !== 2'b11 || idx0 !== 4'd1 || idx1 !== 4'd2 || dest1 !== 6'd12) begin
            failures++;
            $display("FAIL b2b_e4: got v=%b idx0=%0d idx1=%0d d1=%0d want 11/1/2/12",
                     iss_valid, idx0, idx1, dest1);
        end
        fu_ready = 2'b11;
        tick();
        checks++;
        if (iss_valid !== 2'b00 || disp_idx !== 4'd0 || rs_full !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got v=%b didx=%0d full=%b want 00/0/0",
                     iss_valid, disp_idx, rs_full);
        end
    endtask

    task automatic test_fill_wakeup;
        fu_ready = 2'b00;
        for (int i = 0; i < RS_N; i++) begin
            checks++;
            if (disp_idx !== RS_IDX_W'(i)) begin
                failures++;
                $display("FAIL fill_idx_%0d: got %0d want %0d", i, disp_idx, i);
            end
            set_disp(1'b1, 6'd5, 1'b0, 6'd7, 1'b1, TAG_W'(i));
            tick();
        end
        disp_en = 1'b0;
        checks++;
        if (rs_full !== 1'b1 || disp_idx !== 4'd0 || iss_valid !== 2'b00) begin
            failures++;
            $display("FAIL fill_full: got full=%b didx=%0d v=%b want 1/0/00",
                     rs_full, disp_idx, iss_valid);
        end
        cdb_en  = 2'b10;
        cdb_tag = {6'd5, 6'd0};
        tick();
        cdb_en  = 2'b00;
        checks++;
        if (iss_valid !== 2'b00) begin
            failures++;
            $display("FAIL fill_wake_edge: got v=%b want 00", iss_valid);
        end
        tick();
        checks++;
        if (iss_valid !== 2'b11 || idx0 !== 4'd0 || idx1 !== 4'd15 ||
            dest0 !== 6'd0 || dest1 !== 6'd15 || rs_full !== 1'b1) begin
            failures++;
            $display("FAIL fill_issue: got v=%b i0=%0d i1=%0d d0=%0d d1=%0d full=%b want 11/0/15/0/15/1",
                     iss_valid, idx0, idx1, dest0, dest1, rs_full);
        end
        fu_ready = 2'b11;
        tick();
        checks++;
        if (iss_valid !== 2'b11 || idx0 !== 4'd1 || idx1 !== 4'd14 ||
            rs_full !== 1'b0 || disp_idx !== 4'd0) begin
            failures++;
            $display("FAIL fill_b2b: got v=%b i0=%0d i1=%0d full=%b didx=%0d want 11/1/14/0/0",
                     iss_valid, idx0, idx1, rs_full, disp_idx);
        end
        fu_ready = 2'b00;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        checks++;
        if (iss_valid !== 2'b00 || rs_full !== 1'b0 || disp_idx !== 4'd0) begin
            failures++;
            $display("FAIL fill_flush: got v=%b full=%b didx=%0d want 00/0/0",
                     iss_valid, rs_full, disp_idx);
        end
    endtask

    task automatic test_hold_stable;
        fu_ready = 2'b00;
        for (int i = 0; i < 8; i++) begin
            set_disp(1'b1, (i == 3) ? 6'd21 : 6'd20, (i == 7), 6'd7, 1'b1, TAG_W'(30 + i));
            tick();
        end
        disp_en = 1'b0;
        tick();
        checks++;
        if (iss_valid !== 2'b01 || idx0 !== 4'd7 || dest0 !== 6'd37 || disp_idx !== 4'd8) begin
            failures++;
            $display("FAIL single_issue: got v=%b i0=%0d d0=%0d didx=%0d want 01/7/37/8",
                     iss_valid, idx0, dest0, disp_idx);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (iss_valid !== 2'b01 || idx0 !== 4'd7 || dest0 !== 6'd37) begin
                failures++;
                $display("FAIL hold_%0d: got v=%b i0=%0d d0=%0d want 01/7/37",
                         c, iss_valid, idx0, dest0);
            end
        end
        cdb_en  = 2'b01;
        cdb_tag = {6'd0, 6'd21};
        tick();
        cdb_en  = 2'b00;
        checks++;
        if (iss_valid !== 2'b01 || idx0 !== 4'd7) begin
            failures++;
            $display("FAIL no_preempt_edge: got v=%b i0=%0d want 01/7", iss_valid, idx0);
        end
        tick();
        checks++;
        if (iss_valid !== 2'b11 || idx0 !== 4'd7 || idx1 !== 4'd3 || dest1 !== 6'd33) begin
            failures++;
            $display("FAIL no_preempt: got v=%b i0=%0d i1=%0d d1=%0d want 11/7/3/33",
                     iss_valid, idx0, idx1, dest1);
        end
    endtask

    task automatic test_flush;
        flush = 1'b1;
        set_disp(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd50);
        tick();
        flush   = 1'b0;
        disp_en = 1'b0;
        checks++;
        if (iss_valid !== 2'b00 || rs_full !== 1'b0 || disp_idx !== 4'd0) begin
            failures++;
            $display("FAIL flush_state: got v=%b full=%b didx=%0d want 00/0/0",
                     iss_valid, rs_full, disp_idx);
        end
        fu_ready = 2'b11;
        tick();
        checks++;
        if (iss_valid !== 2'b00 || disp_idx !== 4'd0) begin
            failures++;
            $display("FAIL flush_disp_dropped: got v=%b didx=%0d want 00/0", iss_valid, disp_idx);
        end
    endtask

    task automatic test_disp_bypass;
        fu_ready = 2'b11;
        set_disp(1'b1, 6'd1, 1'b1, 6'd9, 1'b0, 6'd44);
        cdb_en  = 2'b01;
        cdb_tag = {6'd0, 6'd9};
        tick();
        disp_en = 1'b0;
        cdb_en  = 2'b00;
        checks++;
        if (iss_valid !== 2'b00 || disp_idx !== 4'd1) begin
            failures++;
            $display("FAIL bypass_edge: got v=%b didx=%0d want 00/1", iss_valid, disp_idx);
        end
        tick();
        checks++;
        if (iss_valid !== 2'b01 || idx0 !== 4'd0 || dest0 !== 6'd44) begin
            failures++;
            $display("FAIL bypass_issue: got v=%b i0=%0d d0=%0d want 01/0/44", iss_valid, idx0, dest0);
        end
        tick();
        checks++;
        if (iss_valid !== 2'b00 || disp_idx !== 4'd0) begin
            failures++;
            $display("FAIL bypass_drain: got v=%b didx=%0d want 00/0", iss_valid, disp_idx);
        end
    endtask

    task automatic test_dual_wake;
        fu_ready = 2'b11;
        set_disp(1'b1, 6'd12, 1'b0, 6'd13, 1'b0, 6'd45);
        tick();
        disp_en = 1'b0;
        cdb_en  = 2'b11;
        cdb_tag = {6'd14, 6'd14};
        tick();
        cdb_en  = 2'b00;
        tick();
        checks++;
        if (iss_valid !== 2'b00) begin
            failures++;
            $display("FAIL wake_unrelated: got v=%b want 00", iss_valid);
        end
        cdb_en  = 2'b11;
        cdb_tag = {6'd13, 6'd12};
        tick();
        cdb_en  = 2'b00;
        tick();
        checks++;
        if (iss_valid !== 2'b01 || idx0 !== 4'd0 || dest0 !== 6'd45) begin
            failures++;
            $display("FAIL wake_dual: got v=%b i0=%0d d0=%0d want 01/0/45", iss_valid, idx0, dest0);
        end
        tick();
        checks++;
        if (iss_valid !== 2'b00) begin
            failures++;
            $display("FAIL wake_drain: got v=%b want 00", iss_valid);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fill_wakeup();
        test_hold_stable();
        test_flush();
        test_disp_bypass();
        test_dual_wake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_issue_sched.md
# rs_issue_sched

Issue scheduler for a 16-entry reservation station. It tracks entry occupancy and operand readiness, captures wakeup tags from the two-wide CDB, and selects up to two ready entries per cycle: the lowest-indexed and the highest-indexed. It hands each selection to a functional-unit port through a registered valid/ready handshake. It sits between dispatch and the two issue ports, and drives RS payload-read indices.

## Interface
- `RS_N`, 16, reservation station entries (power of two)
- `TAG_W`, 6, physical register tag width
- `clock` in 1: rising-edge clock
- `reset_n` in 1: synchronous active-low reset
- `disp_en` in 1: write one new entry this cycle
- `disp_src1_tag`, `disp_src2_tag` in TAG_W: source tags
- `disp_src1_rdy`, `disp_src2_rdy` in 1: source already available
- `disp_dest_tag` in TAG_W: destination tag, stored per entry
- `disp_idx` out log2(RS_N): entry that `disp_en` writes (lowest free)
- `rs_full` out 1: no free entry
- `cdb_en` in 2: per-lane broadcast valid
- `cdb_tag` in 2×TAG_W: broadcast tags
- `flush` in 1: squash all entries and held issues
- `iss_valid` out 2: port 0 and port 1 hold an issued entry
- `iss_idx` out 2×log2(RS_N): held entry index (payload read)
- `iss_dest_tag` out 2×TAG_W: held entry destination tag
- `fu_ready` in 2: port accepts this cycle

## Operation
- Per-entry state:
  - `valid`
  - `held`: owned by a port
  - `src1_tag`, `src2_tag`, `src1_rdy`, `src2_rdy`
  - `dest_tag`
- An entry is eligible when `valid & src1_rdy & src2_rdy & ~held`.
- **Dispatch:**
  - `disp_idx` is the lowest index with `valid==0`. When `rs_full`, it is 0.
  - `disp_en` while `rs_full` is ignored. A bench assertion flags it.
  - An entry freed this cycle cannot be reallocated until the next cycle.
  - `disp_src*_rdy` is ORed with a same-cycle CDB tag match before the write.
- **Wakeup:** every valid entry whose `src*_tag` equals `cdb_tag[k]` with `cdb_en[k]` sets the matching rdy bit. Both lanes apply in the same cycle.
- **Each port is a 2-state FSM, IDLE→HOLD→IDLE:**
  - IDLE, with a candidate: load the candidate, set its `held`, go to HOLD.
  - HOLD, `fu_ready` high: clear `valid` and `held` of the entry (entry freed). Then load a new candidate in the same edge if one exists, otherwise go to IDLE.
  - HOLD, `fu_ready` low: hold `iss_idx` and `iss_dest_tag` stable.
- **Candidate selection**, made from the eligible mask at the current cycle:
  - Port 0 takes the lowest eligible index.
  - Port 1 takes the highest eligible index.
  - If only one entry is eligible and both ports are loading, port 0 takes it and port 1 stays or returns to IDLE.
  - An entry is never loaded into both ports.
- **Flush:** clears all `valid` and `held` bits and forces both FSMs to IDLE. Dispatch, wakeup and loads in the same cycle are discarded. Flush beats dispatch.

## Timing
- Reset values (`reset_n` low at an edge):
  - all entries invalid
  - `iss_valid=2'b00`, `iss_idx=0`, `iss_dest_tag=0`
  - `disp_idx=0`, `rs_full=0`
- `iss_*` are registered outputs. `disp_idx` and `rs_full` are combinational from state.
- Latency:
  - Dispatch with both sources ready at edge t → `iss_valid` at edge t+1.
  - CDB wakeup at edge t → earliest `iss_valid` at edge t+1.
- Back-to-back issue: with `fu_ready` held high, a port delivers one entry per cycle.
- A lower-index entry becoming eligible while a port is in HOLD does not preempt the held entry.

## Structure
- Shared package `rs_pkg`:
  - `RS_N`, `TAG_W`, `RS_IDX_W`
  - the port FSM state enum `{ISS_IDLE, ISS_HOLD}`
- Sub-module `rs_pick2`: combinational, `RS_N`-bit mask in → lowest index + valid, highest index + valid, and a distinct flag. One instance for the eligible mask. A second instance (lowest only) for the free mask.
- Everything else (entry array, FSMs, wakeup compare) lives in `rs_issue_sched`.

## Test plan
- Reset then idle: `rs_full=0`, `disp_idx=0`, `iss_valid=00` for 5 cycles.
- Dispatch 3 ready entries (idx 0,1,2) with `fu_ready=11`:
  - port 0 issues 0 then 1
  - port 1 issues 2
  - all freed
  - `disp_idx` returns to 0
- Fill all 16 with `src1_tag=5`, not ready:
  - `rs_full=1`, `iss_valid=00`
  - CDB lane 1 tag 5 → next cycle port 0 idx 0, port 1 idx 15
- Single eligible entry idx 7: port 0 idx 7, port 1 idle. With `fu_ready=0` for 4 cycles, idx 7 is held stable. A new ready entry at idx 3 goes to port 1, not port 0.
- Dispatch with `src2_tag=9` while CDB lane 0 broadcasts tag 9 in the same cycle → issued the next cycle.
- Flush while both ports are in HOLD and `disp_en=1`: next cycle `iss_valid=00`, `rs_full=0`, `disp_idx=0`, and the dispatched entry is absent.
